// File: rtl/sum_splitter.sv
// sum_splitter: takes a target sum and streams every operand pair (a, b)
// with a + b == target, a ascending, one pair per valid/ready handshake.
// Targets above 2*MAX are rejected with an err pulse and no pairs.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   start      request decomposition of target (sampled only in IDLE)
//   target     W+1 bit sum, latched on an accepted start
//   out_ready  downstream accepts the current pair
//   out_valid  a/b/last carry a valid pair
//   a, b       operand pair, b == latched target - a
//   last       current pair is the final one of the request
//   busy       high while emitting and in the closing DONE cycle
//   done       one-cycle pulse at the end of a request
//   err        one-cycle pulse alongside done for an out-of-range target
//   pair_cnt   number of pairs for the latched target, 0 on error
module sum_splitter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W:0]   target,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         last,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W:0]   pair_cnt
);

  localparam int unsigned SW        = W + 1;
  localparam int unsigned MAX_INT   = (1 << W) - 1;
  localparam logic [SW-1:0] MAX_S     = SW'(MAX_INT);
  localparam logic [SW-1:0] TWO_MAX_S = SW'(2 * MAX_INT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Upper bound of a for the active request; terminates the sweep.
  logic [W-1:0]  hi_q;
  logic [W-1:0]  hi_d;

  logic          valid_d;
  logic [W-1:0]  a_d;
  logic [W-1:0]  b_d;
  logic          last_d;
  logic          busy_d;
  logic          done_d;
  logic          err_d;
  logic [SW-1:0] cnt_d;

  logic          handshake;
  logic          target_bad;
  logic [SW-1:0] lo_s;
  logic [SW-1:0] hi_s;

  assign handshake  = out_valid & out_ready;
  assign target_bad = (target > TWO_MAX_S);

  // Range of a for the incoming target: lo = max(0, S-MAX), hi = min(S, MAX).
  always_comb begin
    lo_s = '0;
    hi_s = target;
    if (target > MAX_S) begin
      lo_s = target - MAX_S;
      hi_s = MAX_S;
    end
  end

  // State register plus registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      out_valid <= valid_d;
      a         <= a_d;
      b         <= b_d;
      last      <= last_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      pair_cnt  <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = target_bad ? DONE : EMIT;
        end
      end
      EMIT: begin
        if (handshake && last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and the sweep bound.
  always_comb begin
    hi_d    = hi_q;
    valid_d = out_valid;
    a_d     = a;
    b_d     = b;
    last_d  = last;
    cnt_d   = pair_cnt;
    err_d   = 1'b0;
    // busy/done follow the state being entered so they line up with it.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (start) begin
          if (target_bad) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            a_d     = W'(lo_s);
            b_d     = W'(target - lo_s);
            hi_d    = W'(hi_s);
            cnt_d   = hi_s - lo_s + SW'(1);
            last_d  = (lo_s == hi_s);
            valid_d = 1'b1;
          end
        end
      end
      EMIT: begin
        // Data only moves on a handshake, so an unaccepted pair holds.
        if (handshake) begin
          if (last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            // a < hi <= MAX here, so neither a+1 nor b-1 can wrap.
            a_d    = a + W'(1);
            b_d    = b - W'(1);
            last_d = ((a + W'(1)) == hi_q);
          end
        end
      end
      DONE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/sum_splitter.md
Name: sum_splitter

Overview:
- Inverse companion to the team's registered nibble adder: accepts a target sum and streams every operand pair (a, b) whose sum equals it.
- Pairs leave one per accepted handshake, ordered by ascending a.
- Used to generate exhaustive stimulus for the adder tile and as a standalone demo block.
- Single FSM plus one operand counter; all outputs registered.

Parameters:
W, 4, operand width in bits; target is W+1 bits; MAX = 2^W-1

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request decomposition of target; sampled only in IDLE
target  input  W+1  sum to split, latched on accepted start
out_ready  input  1  downstream accepts current pair
out_valid  output  1  a/b/last hold a valid pair
a  output  W  first operand
b  output  W  second operand, always target_latched - a
last  output  1  current pair is the final one
busy  output  1  high in EMIT and DONE
done  output  1  one-cycle pulse at end of a request
err  output  1  one-cycle pulse with done when target > 2*MAX
pair_cnt  output  W+1  total pairs for the latched target, 0 on error

Behaviour:
- Reset is asynchronous and active-high: reset; clock is clk. While reset is high, FSM = IDLE and all outputs = 0, including a, b, pair_cnt and last.
- States: IDLE, EMIT, DONE.
- IDLE: start=1 latches S=target.
  - If S > 2*MAX: go to DONE with err set; out_valid stays 0; pair_cnt=0.
  - Otherwise lo = max(0, S-MAX), hi = min(S, MAX); a <= lo, b <= S-lo, pair_cnt <= hi-lo+1, last <= (lo==hi), out_valid <= 1; go to EMIT.
- Latency: start accepted in cycle N gives the first pair with out_valid=1 in cycle N+1.
- EMIT: a handshake is out_valid & out_ready.
  - No handshake: a, b, last and out_valid hold stable. Data must never change while valid is unaccepted.
  - Handshake with last=0: a <= a+1, b <= b-1, last <= (a+1 == hi), out_valid stays 1. This gives back-to-back pairs every cycle while out_ready=1.
  - Handshake with last=1: out_valid <= 0; go to DONE.
- DONE: lasts exactly one cycle with done=1 (and err=1 if the error path was taken), then returns to IDLE. busy=1 in this state.
- IDLE after DONE: a, b and pair_cnt keep their last values; last=0, out_valid=0.
- start is ignored in EMIT and DONE. A start held high continuously is re-accepted on the first IDLE cycle.
- Arithmetic: a and b never wrap. Counter math is done in W+1 bits; b = S - a truncated to W bits is exact in range.
- Boundary cases:
  - S=0: single pair (0,0), last=1 on the first beat.
  - S=2*MAX: single pair (MAX,MAX).
  - S=MAX: MAX+1 pairs, the largest count.
- Reset mid-EMIT: immediate return to IDLE with all outputs 0. No done pulse is generated for the aborted request.

Test Plan:
- Reset then start with target=0, out_ready=1 -> cycle+1: valid, a=0, b=0, last=1, pair_cnt=1; next cycle done=1, busy=1; then IDLE.
- target=20, out_ready=1 -> 11 consecutive valid beats a=5..15 / b=15..5, last only on (15,5), pair_cnt=11, then a single done pulse.
- target=15 with out_ready toggling 1,0,0,1,... -> 16 pairs (0,15)..(15,0). Each pair is held stable through its ready=0 cycles; no pair is dropped or duplicated.
- target=31 -> no valid beats; one cycle later done=1 and err=1 together, pair_cnt=0.
- target=30 -> single beat (15,15) with last=1. A start pulse issued during EMIT or DONE is ignored, shown by pair_cnt staying 1 and no second sequence.
- target=10, assert reset after the 3rd accepted beat -> out_valid, a, b, busy and pair_cnt go to 0 immediately, no done pulse. A new start with target=1 yields (0,1),(1,0).
